// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP sampler.
// The optional threshold alarm is enabled with XADC_SAMPLER_ALARM_EN.
package xadc_pkg;

  localparam int SAMPLE_W = 12;

  localparam logic [6:0] DRP_ADDR_TEMP   = 7'h00;
  localparam logic [6:0] DRP_ADDR_VCCINT = 7'h01;
  localparam logic [6:0] DRP_ADDR_VAUX6  = 7'h16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    ACC  = 3'd3,
    OUT  = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/xadc_accum.sv
// Sample accumulator: sums 2**AVG_LOG2 samples and presents the truncated mean.
// The count wraps to zero on the last sample so the block is ready for the next batch.
module xadc_accum
  import xadc_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                add_en,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                last,
  output logic [SAMPLE_W-1:0] mean
);

  localparam int ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (clear) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (add_en) begin
      acc_reg <= acc_reg + ACC_W'(sample);
      cnt_reg <= last ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  assign last = (cnt_reg == CNT_LAST);
  // Divide by the batch size with a shift; the accumulator is wide enough never to overflow.
  assign mean = acc_reg[AVG_LOG2 +: SAMPLE_W];

endmodule

// File: rtl/xadc_drp_sampler.sv
// Reads one XADC channel over DRP per end-of-conversion, averages and streams the result.
// Defining XADC_SAMPLER_ALARM_EN adds thresh_hi/alarm and a high-threshold comparator.
module xadc_drp_sampler
  import xadc_pkg::*;
#(
  parameter logic [6:0] DRP_ADDR    = DRP_ADDR_VAUX6,
  parameter int         AVG_LOG2    = 2,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                eoc_in,
  input  logic                drdy_in,
  input  logic [15:0]         do_in,
  output logic                den_out,
  output logic [6:0]          daddr_out,
  output logic                dwe_out,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef XADC_SAMPLER_ALARM_EN
  input  logic [SAMPLE_W-1:0] thresh_hi,
  output logic                alarm,
`endif
  output logic [7:0]          overrun_cnt,
  output logic                timeout_err
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t              state_reg, state_next;
  logic [TMR_W-1:0]    timer_reg;
  logic [SAMPLE_W-1:0] sample_reg;
  logic [7:0]          overrun_reg;
  logic                timeout_reg;
  logic                acc_last;
  logic                handshake;
  logic                timeout_hit;
  logic                unused_do_lsbs;

  assign unused_do_lsbs = ^do_in[3:0];

  assign daddr_out   = DRP_ADDR;
  assign dwe_out     = 1'b0;
  assign overrun_cnt = overrun_reg;
  assign timeout_err = timeout_reg;
  assign handshake   = out_valid && out_ready;
  assign timeout_hit = (state_reg == WAIT) && !drdy_in && (timer_reg == TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    den_out    = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: if (eoc_in) state_next = REQ;
      REQ: begin
        den_out    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (drdy_in) state_next = ACC;
        else if (timeout_hit) state_next = IDLE;
      end
      ACC:  state_next = acc_last ? OUT : IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg   <= '0;
      sample_reg  <= '0;
      overrun_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (state_reg == REQ) timer_reg <= '0;
      else if (state_reg == WAIT) timer_reg <= timer_reg + TMR_W'(1);
      if ((state_reg == WAIT) && drdy_in) sample_reg <= do_in[15:4];
      // Conversions arriving mid-transaction are counted and dropped.
      if (eoc_in && (state_reg != IDLE)) overrun_reg <= sat_inc8(overrun_reg);
      if (timeout_hit) timeout_reg <= 1'b1;
    end
  end

  xadc_accum #(
    .AVG_LOG2(AVG_LOG2)
  ) u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .add_en(state_reg == ACC),
    .clear (handshake),
    .sample(sample_reg),
    .last  (acc_last),
    .mean  (out_data)
  );

`ifdef XADC_SAMPLER_ALARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (handshake) begin
      alarm <= (out_data > thresh_hi);
    end
  end
`endif

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Bench for xadc_drp_sampler: two instances (pass-through and 4-sample average) share stimulus.
// Covers XADC_SAMPLER_ALARM_EN when that macro is defined.
module tb_xadc_drp_sampler;

  localparam int TO_CYC = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eoc = 1'b0;
  logic        drdy = 1'b0;
  logic [15:0] din = '0;
  logic        ready0 = 1'b1;
  logic        ready2 = 1'b1;

  logic        den0, dwe0, v0, to0, den2, dwe2, v2, to2;
  logic [6:0]  daddr0, daddr2;
  logic [11:0] od0, od2;
  logic [7:0]  ov0, ov2;
`ifdef XADC_SAMPLER_ALARM_EN
  logic [11:0] thresh = 12'h800;
  logic        alarm0, alarm2;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  xadc_drp_sampler #(.AVG_LOG2(0), .TIMEOUT_CYC(TO_CYC)) dut0 (
    .clk(clk), .rst_n(rst_n), .eoc_in(eoc), .drdy_in(drdy), .do_in(din),
    .den_out(den0), .daddr_out(daddr0), .dwe_out(dwe0),
    .out_data(od0), .out_valid(v0), .out_ready(ready0),
`ifdef XADC_SAMPLER_ALARM_EN
    .thresh_hi(thresh), .alarm(alarm0),
`endif
    .overrun_cnt(ov0), .timeout_err(to0)
  );

  xadc_drp_sampler #(.AVG_LOG2(2), .TIMEOUT_CYC(TO_CYC)) dut2 (
    .clk(clk), .rst_n(rst_n), .eoc_in(eoc), .drdy_in(drdy), .do_in(din),
    .den_out(den2), .daddr_out(daddr2), .dwe_out(dwe2),
    .out_data(od2), .out_valid(v2), .out_ready(ready2),
`ifdef XADC_SAMPLER_ALARM_EN
    .thresh_hi(thresh), .alarm(alarm2),
`endif
    .overrun_cnt(ov2), .timeout_err(to2)
  );

  // Transaction monitors: every accepted output word and every DRP enable pulse.
  logic [11:0] got0[$];
  logic [11:0] got2[$];
  int den_cnt0 = 0;
  int rd0 = 0;
  int rd2 = 0;

  always @(posedge clk) begin
    if (v0 && ready0) got0.push_back(od0);
    if (v2 && ready2) got2.push_back(od2);
    if (den0) den_cnt0 <= den_cnt0 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic pop0(input string name, input logic [11:0] exp);
    if (rd0 < got0.size()) begin
      check(name, 32'(got0[rd0]), 32'(exp));
      rd0++;
    end else begin
      check({name, "_missing"}, 32'(got0.size() - rd0), 32'd1);
    end
  endtask

  task automatic pop2(input string name, input logic [11:0] exp);
    if (rd2 < got2.size()) begin
      check(name, 32'(got2[rd2]), 32'(exp));
      rd2++;
    end else begin
      check({name, "_missing"}, 32'(got2.size() - rd2), 32'd1);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    eoc = 1'b0;
    drdy = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) next();
    rst_n = 1'b1;
    next();
    rd0 = got0.size();
    rd2 = got2.size();
  endtask

  // One read: eoc, then drdy 'dly' cycles into WAIT (or never), then 'gap' idle cycles.
  task automatic do_read(input logic [15:0] word, input int dly, input bit drop, input int gap);
    eoc = 1'b1;
    next();
    eoc = 1'b0;
    next();
    if (drop) begin
      repeat (TO_CYC + 2) next();
    end else begin
      repeat (dly) next();
      drdy = 1'b1;
      din = word;
      next();
      drdy = 1'b0;
      din = 16'h5A5A;
    end
    repeat (gap) next();
  endtask

  typedef struct {
    logic [15:0] do_word;
    logic [11:0] exp0;
    bit          chk2;
    logic [11:0] exp2;
  } vec_t;

  vec_t tbl[8];

  logic [11:0] m0[$];
  logic [11:0] m2[$];

  initial begin
    int d0;
    bit flag;
    bit any_drop;
    int psum;
    int pn;

    tbl[0] = '{16'h1000, 12'h100, 1'b0, 12'h000};
    tbl[1] = '{16'h1010, 12'h101, 1'b0, 12'h000};
    tbl[2] = '{16'h1020, 12'h102, 1'b0, 12'h000};
    tbl[3] = '{16'h1050, 12'h105, 1'b1, 12'h102};
    tbl[4] = '{16'hABC0, 12'hABC, 1'b0, 12'h000};
    tbl[5] = '{16'hFFFF, 12'hFFF, 1'b0, 12'h000};
    tbl[6] = '{16'h0000, 12'h000, 1'b0, 12'h000};
    tbl[7] = '{16'h000F, 12'h000, 1'b1, 12'h6AE};

    // Reset values
    repeat (2) next();
    @(negedge clk);
    check("rst_den", 32'(den0), 0);
    check("rst_valid", 32'({v0, v2}), 0);
    check("rst_daddr", 32'({daddr0, daddr2}), 32'({7'h16, 7'h16}));
    check("rst_dwe", 32'({dwe0, dwe2}), 0);
    check("rst_data", 32'({od0, od2}), 0);
    check("rst_overrun", 32'({ov0, ov2}), 0);
    check("rst_timeout", 32'({to0, to2}), 0);
    rst_n = 1'b1;
    next();

    // Latency, pass-through: eoc in cycle 0, drdy in cycle 3, valid in cycle 5
    ready0 = 1'b0;
    eoc = 1'b1;
    @(negedge clk);
    check("lat_c0_den", 32'(den0), 0);
    next();
    eoc = 1'b0;
    @(negedge clk);
    check("lat_c1_den", 32'(den0), 1);
    next();
    @(negedge clk);
    check("lat_c2_den", 32'(den0), 0);
    next();
    drdy = 1'b1;
    din = 16'hABC0;
    next();
    drdy = 1'b0;
    @(negedge clk);
    check("lat_c4_valid", 32'(v0), 0);
    next();
    @(negedge clk);
    check("lat_c5_valid", 32'(v0), 1);
    check("lat_c5_data", 32'(od0), 32'h0ABC);
    next();
    @(negedge clk);
    check("lat_c6_hold", 32'({v0, od0}), 32'h1ABC);
    ready0 = 1'b1;
    next();
    @(negedge clk);
    check("lat_c7_drop", 32'(v0), 0);
    pop0("lat_accept", 12'hABC);

    // Table-driven vectors
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_read(tbl[i].do_word, 1 + (i % 3), 1'b0, 3);
      pop0($sformatf("tbl%0d_pass", i), tbl[i].exp0);
      if (tbl[i].chk2) pop2($sformatf("tbl%0d_avg", i), tbl[i].exp2);
      else check($sformatf("tbl%0d_noavg", i), 32'(got2.size() - rd2), 0);
    end

    // Backpressure: output held while three conversions are dropped
    do_reset();
    ready0 = 1'b0;
    do_read(16'h1230, 0, 1'b0, 2);
    d0 = den_cnt0;
    flag = 1'b0;
    for (int c = 0; c < 20; c++) begin
      eoc = (c == 2 || c == 8 || c == 14);
      @(negedge clk);
      if (!v0 || od0 !== 12'h123) flag = 1'b1;
      next();
    end
    eoc = 1'b0;
    check("bp_stable", 32'(flag), 0);
    check("bp_overrun", 32'(ov0), 3);
    check("bp_no_den", 32'(den_cnt0 - d0), 0);
    ready0 = 1'b1;
    next();
    @(negedge clk);
    check("bp_release", 32'(v0), 0);
    pop0("bp_accept", 12'h123);

    // drdy timeout
    do_reset();
    d0 = den_cnt0;
    eoc = 1'b1;
    next();
    eoc = 1'b0;
    repeat (64) next();
    @(negedge clk);
    check("to_early", 32'(to0), 0);
    next();
    @(negedge clk);
    check("to_set", 32'(to0), 1);
    check("to_no_output", 32'(got0.size() - rd0), 0);
    do_read(16'h7770, 2, 1'b0, 3);
    pop0("to_recover", 12'h777);
    check("to_den_count", 32'(den_cnt0 - d0), 2);
    check("to_sticky", 32'(to0), 1);

    // Reset during WAIT, stale drdy after release
    do_reset();
    eoc = 1'b1;
    next();
    eoc = 1'b0;
    repeat (2) next();
    rst_n = 1'b0;
    repeat (2) next();
    rst_n = 1'b1;
    d0 = den_cnt0;
    drdy = 1'b1;
    din = 16'hFFF0;
    next();
    drdy = 1'b0;
    flag = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (v0 || v2) flag = 1'b1;
      next();
    end
    check("rstw_no_valid", 32'(flag), 0);
    check("rstw_no_den", 32'(den_cnt0 - d0), 0);
    check("rstw_no_output", 32'(got0.size() - rd0), 0);
    for (int i = 0; i < 4; i++) begin
      do_read(16'h0450, 1, 1'b0, 3);
      pop0($sformatf("rstw_pass%0d", i), 12'h045);
    end
    pop2("rstw_avg_clean", 12'h045);

    // Randomized reads against a batch-average reference
    do_reset();
    m0.delete();
    m2.delete();
    any_drop = 1'b0;
    psum = 0;
    pn = 0;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] w;
      bit drop;
      w = 16'($urandom);
      drop = ($urandom_range(0, 9) == 0);
      do_read(w, $urandom_range(0, 10), drop, $urandom_range(2, 6));
      if (drop) begin
        any_drop = 1'b1;
      end else begin
        m0.push_back(w[15:4]);
        psum += int'(w[15:4]);
        pn++;
        if (pn == 4) begin
          m2.push_back(12'(psum / 4));
          psum = 0;
          pn = 0;
        end
      end
    end
    check("rnd_count0", 32'(got0.size() - rd0), 32'(m0.size()));
    check("rnd_count2", 32'(got2.size() - rd2), 32'(m2.size()));
    foreach (m0[i]) pop0($sformatf("rnd_pass%0d", i), m0[i]);
    foreach (m2[i]) pop2($sformatf("rnd_avg%0d", i), m2[i]);
    check("rnd_timeout", 32'({to0, to2}), any_drop ? 32'h3 : 32'h0);
    check("rnd_overrun", 32'({ov0, ov2}), 0);

`ifdef XADC_SAMPLER_ALARM_EN
    do_reset();
    @(negedge clk);
    check("alarm_rst", 32'(alarm0), 0);
    next();
    do_read(16'h8010, 1, 1'b0, 3);
    pop0("alarm_hi_data", 12'h801);
    check("alarm_hi", 32'(alarm0), 1);
    do_read(16'h8000, 1, 1'b0, 3);
    pop0("alarm_eq_data", 12'h800);
    check("alarm_eq", 32'(alarm0), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
